// File: rtl/uart_pkg.sv
// Shared 8N1 framing constants and the FSM state encoding used by both
// the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned DataBits = 8;
  localparam int unsigned StopBits = 1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StStart   = 3'd1,
    StData    = 3'd2,
    StStop    = 3'd3,
    StCleanup = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: counts 0..ClksPerBit-1 and wraps to 0.
// It also returns to 0 whenever clear_i is high.
module uart_bit_timer #(
  parameter int unsigned ClksPerBit = 87
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic mid_o,
  output logic term_o
);

  localparam int unsigned CntW = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] MidCnt  = CntW'((ClksPerBit - 1) / 2);
  localparam logic [CntW-1:0] TermCnt = CntW'(ClksPerBit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign mid_o  = (cnt_q == MidCnt);
  assign term_o = (cnt_q == TermCnt);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear_i || term_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_tx.sv
// Independent 8N1 UART transmitter and receiver sharing one clock and a
// synchronous active-high reset.
module uart_rx_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte
);

  localparam logic [2:0] LastIdx = 3'(DataBits - 1);

  uart_state_e tx_state_q, tx_state_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic        tx_clear, tx_term, tx_mid_unused;

  uart_bit_timer #(.ClksPerBit(CLKS_PER_BIT)) u_tx_timer (
    .clk_i  (i_Clock),
    .rst_i  (i_Reset),
    .clear_i(tx_clear),
    .mid_o  (tx_mid_unused),
    .term_o (tx_term)
  );

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_byte_d   = tx_byte_q;
    tx_idx_d    = tx_idx_q;
    tx_clear    = 1'b0;
    o_Tx_Serial = 1'b1;
    o_Tx_Active = 1'b0;
    o_Tx_Done   = 1'b0;
    unique case (tx_state_q)
      StIdle: begin
        tx_clear = 1'b1;
        tx_idx_d = '0;
        if (i_Tx_DV) begin
          tx_byte_d  = i_Tx_Byte;
          tx_state_d = StStart;
        end
      end
      StStart: begin
        o_Tx_Serial = 1'b0;
        o_Tx_Active = 1'b1;
        if (tx_term) tx_state_d = StData;
      end
      StData: begin
        o_Tx_Serial = tx_byte_q[tx_idx_q];
        o_Tx_Active = 1'b1;
        if (tx_term) begin
          if (tx_idx_q == LastIdx) begin
            tx_idx_d   = '0;
            tx_state_d = StStop;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        o_Tx_Active = 1'b1;
        if (tx_term) tx_state_d = StCleanup;
      end
      StCleanup: begin
        o_Tx_Done  = 1'b1;
        tx_clear   = 1'b1;
        tx_state_d = StIdle;
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      tx_state_q <= StIdle;
      tx_byte_q  <= '0;
      tx_idx_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_byte_q  <= tx_byte_d;
      tx_idx_q   <= tx_idx_d;
    end
  end

  // RX line is asynchronous; only rx_sync_q[1] is safe to use.
  logic [1:0]  rx_sync_q;
  logic        rx_bit;
  uart_state_e rx_state_q, rx_state_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic        rx_ok_q, rx_ok_d;
  logic        rx_clear, rx_mid, rx_term;

  assign rx_bit    = rx_sync_q[1];
  assign o_Rx_Byte = rx_byte_q;

  uart_bit_timer #(.ClksPerBit(CLKS_PER_BIT)) u_rx_timer (
    .clk_i  (i_Clock),
    .rst_i  (i_Reset),
    .clear_i(rx_clear),
    .mid_o  (rx_mid),
    .term_o (rx_term)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_idx_d   = rx_idx_q;
    rx_ok_d    = rx_ok_q;
    rx_clear   = 1'b0;
    o_Rx_DV    = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        rx_clear = 1'b1;
        rx_idx_d = '0;
        if (!rx_bit) rx_state_d = StStart;
      end
      StStart: begin
        // Re-align the timer to mid start bit so later terminals land mid-bit.
        if (rx_mid) begin
          if (!rx_bit) begin
            rx_clear   = 1'b1;
            rx_state_d = StData;
          end else begin
            rx_state_d = StIdle;
          end
        end
      end
      StData: begin
        if (rx_term) begin
          rx_shift_d[rx_idx_q] = rx_bit;
          if (rx_idx_q == LastIdx) begin
            rx_idx_d   = '0;
            rx_state_d = StStop;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (rx_term) begin
          rx_ok_d    = rx_bit;
          rx_state_d = StCleanup;
          if (rx_bit) rx_byte_d = rx_shift_q;
        end
      end
      StCleanup: begin
        rx_clear = 1'b1;
        o_Rx_DV  = rx_ok_q;
        // A framing error holds here until the line returns high.
        if (rx_ok_q || rx_bit) begin
          rx_ok_d    = 1'b0;
          rx_state_d = StIdle;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= StIdle;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_idx_q   <= '0;
      rx_ok_q    <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], i_Rx_Serial};
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_idx_q   <= rx_idx_d;
      rx_ok_q    <= rx_ok_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_tx.sv
// Scoreboard bench for uart_rx_tx: stimulus pushes expected bytes/frames,
// independent monitors pop and compare when the DUT presents them.
module tb_uart_rx_tx;

  localparam int CLKS = 87;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_active, tx_serial, tx_done;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_line;
  logic       rx_dv;
  logic [7:0] rx_byte;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rx_dv_cnt = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  assign rx_line = loop_en ? tx_serial : rx_drv;

  always #5 clk = ~clk;

  uart_rx_tx #(.CLKS_PER_BIT(CLKS)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Tx_DV    (tx_dv),
    .i_Tx_Byte  (tx_byte),
    .o_Tx_Active(tx_active),
    .o_Tx_Serial(tx_serial),
    .o_Tx_Done  (tx_done),
    .i_Rx_Serial(rx_line),
    .o_Rx_DV    (rx_dv),
    .o_Rx_Byte  (rx_byte)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tx_send(input logic [7:0] b);
    exp_tx.push_back(b);
    if (loop_en) exp_rx.push_back(b);
    tx_dv   = 1'b1;
    tx_byte = b;
    tick(1);
    tx_dv   = 1'b0;
    tx_byte = ~b;
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (tx_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick(1);
    end
    check("tx_done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [7:0] sh;
    sh = b;
    if (stop) exp_rx.push_back(b);
    rx_drv = 1'b0;
    tick(CLKS);
    for (int i = 0; i < 8; i++) begin
      rx_drv = sh[0];
      sh = sh >> 1;
      tick(CLKS);
    end
    rx_drv = stop;
    tick(CLKS);
    if (stop) check("rx_dv_in_stop_bit", 32'(exp_rx.size()), 32'd0);
    rx_drv = 1'b1;
    tick(20);
  endtask

  // TX monitor: checks every cycle of each frame against the expected level.
  initial begin
    logic [9:0] want, seen;
    logic [7:0] b;
    logic [3:0] bi;
    int bad, act_bad, done_bad;
    logic aborted;
    forever begin
      @(negedge clk);
      if (!rst && tx_serial === 1'b0) begin
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected_frame: line low with no byte queued");
          b = 8'h00;
        end else begin
          b = exp_tx.pop_front();
        end
        want = {1'b1, b, 1'b0};
        seen = '0;
        bad = 0;
        act_bad = 0;
        done_bad = 0;
        aborted = 1'b0;
        for (int c = 0; c < 10 * CLKS; c++) begin
          if (c != 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          bi = 4'(c / CLKS);
          if (tx_serial !== want[bi]) bad++;
          if (c % CLKS == CLKS / 2) seen[bi] = tx_serial;
          if (tx_active !== 1'b1) act_bad++;
          if (tx_done !== 1'b0) done_bad++;
        end
        if (!aborted) begin
          check("tx_frame_bits", 32'(seen), 32'(want));
          check("tx_bit_timing", 32'(bad), 32'd0);
          check("tx_active_in_frame", 32'(act_bad), 32'd0);
          check("tx_no_early_done", 32'(done_bad), 32'd0);
          @(negedge clk);
          check("tx_done_at_870", 32'({tx_done, tx_active}), 32'h2);
          @(negedge clk);
          check("tx_done_single", 32'(tx_done), 32'd0);
        end
      end
    end
  end

  // RX monitor: pops the scoreboard on each DV pulse.
  initial begin
    logic prev_dv;
    prev_dv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && rx_dv === 1'b1) begin
        rx_dv_cnt++;
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected_dv: got byte %0h, none expected", rx_byte);
        end else begin
          check("rx_byte", 32'(rx_byte), 32'(exp_rx.pop_front()));
        end
        if (prev_dv === 1'b1) begin
          checks++;
          errors++;
          $display("FAIL rx_dv_width: got DV high two cycles, want one");
        end
      end
      if (!rst && tx_done === 1'b1) done_cnt++;
      prev_dv = rx_dv;
    end
  end

  initial begin
    int n, d;
    logic [7:0] rb;
    tick(3);
    check("rst_tx_serial", 32'(tx_serial), 32'd1);
    check("rst_tx_active", 32'(tx_active), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_rx_dv", 32'(rx_dv), 32'd0);
    check("rst_rx_byte", 32'(rx_byte), 32'h00);
    rst = 1'b0;
    tick(5);

    tx_send(8'hAB);
    wait_done();
    tick(10);

    send_rx(8'h2F, 1'b1);

    n = rx_dv_cnt;
    rx_drv = 1'b0;
    tick(30);
    rx_drv = 1'b1;
    tick(200);
    check("rx_glitch_no_dv", 32'(rx_dv_cnt), 32'(n));
    send_rx(8'h55, 1'b1);

    n = rx_dv_cnt;
    send_rx(8'hA5, 1'b0);
    tick(100);
    check("rx_frame_err_no_dv", 32'(rx_dv_cnt), 32'(n));
    check("rx_frame_err_hold", 32'(rx_byte), 32'h55);

    loop_en = 1'b1;
    tick(5);
    tx_send(8'h00);
    wait_done();
    tick(1);
    tx_send(8'hFF);
    wait_done();
    tick(1);
    tx_send(8'h81);
    wait_done();
    tick(100);
    check("loop_all_received", 32'(exp_rx.size()), 32'd0);
    check("loop_last_byte", 32'(rx_byte), 32'h81);
    loop_en = 1'b0;
    tick(5);

    // Abort a TX frame in data bit 3 and an RX frame mid data bit 3.
    n = rx_dv_cnt;
    d = done_cnt;
    rb = 8'h3C;
    exp_tx.push_back(8'hC3);
    tx_dv = 1'b1;
    tx_byte = 8'hC3;
    rx_drv = 1'b0;
    tick(1);
    tx_dv = 1'b0;
    tick(CLKS - 1);
    for (int k = 0; k < 3; k++) begin
      rx_drv = rb[0];
      rb = rb >> 1;
      tick(CLKS);
    end
    rx_drv = rb[0];
    tick(40);
    rst = 1'b1;
    rx_drv = 1'b1;
    tick(1);
    check("midrst_tx_serial", 32'(tx_serial), 32'd1);
    check("midrst_tx_active", 32'(tx_active), 32'd0);
    check("midrst_tx_done", 32'(tx_done), 32'd0);
    check("midrst_rx_dv", 32'(rx_dv), 32'd0);
    check("midrst_rx_byte", 32'(rx_byte), 32'h00);
    tick(2);
    rst = 1'b0;
    tick(300);
    check("midrst_no_done", 32'(done_cnt), 32'(d));
    check("midrst_no_dv", 32'(rx_dv_cnt), 32'(n));
    check("midrst_tx_queue", 32'(exp_tx.size()), 32'd0);

    tx_send(8'h5A);
    wait_done();
    tick(5);
    send_rx(8'h96, 1'b1);
    tick(50);
    check("final_tx_queue", 32'(exp_tx.size()), 32'd0);
    check("final_rx_queue", 32'(exp_rx.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
